// File: rtl/rv32i_mc_ctrl.sv
// rtl/rv32i_mc_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencing controller for RV32I
// Optional retired-instruction and cycle counters: define RV32I_CTRL_PERF_CNT_EN.
module rv32i_mc_ctrl #(
    parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] opcode,
    input  logic        br_taken,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        halt,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       taken_q;
    logic [6:0] major;
    logic       is_r, is_i, is_load, is_store, is_branch;
    logic       is_lui, is_auipc, is_jal, is_jalr, legal;
    logic       unused_opcode_bits;

    assign major              = opcode[6:0];
    assign unused_opcode_bits = ^opcode[15:7];

    assign is_r      = (major == 7'b0110011);
    assign is_i      = (major == 7'b0010011);
    assign is_load   = (major == 7'b0000011);
    assign is_store  = (major == 7'b0100011);
    assign is_branch = (major == 7'b1100011);
    assign is_lui    = (major == 7'b0110111);
    assign is_auipc  = (major == 7'b0010111);
    assign is_jal    = (major == 7'b1101111);
    assign is_jalr   = (major == 7'b1100111);
    assign legal     = is_r | is_i | is_load | is_store | is_branch |
                       is_lui | is_auipc | is_jal | is_jalr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            taken_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == EXEC) begin
                taken_q <= br_taken;
            end
        end
    end

    // Reset gates every output combinationally so a pending request drops while rst is held.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        wb_sel     = 2'd0;
        alu_a_sel  = 1'b0;
        alu_b_sel  = 1'b0;
        halt       = 1'b0;
        if (rst) begin
            pc_src = RESET_PC_SEL;
        end else begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                    if (imem_ack) begin
                        state_next = DECODE;
                    end
                end
                DECODE: begin
                    state_next = legal ? EXEC : TRAP;
                end
                EXEC: begin
                    alu_a_sel  = is_auipc | is_jal | is_branch;
                    alu_b_sel  = ~(is_r | is_branch);
                    state_next = (is_load | is_store) ? MEM : WB;
                end
                MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                    if (dmem_ack) begin
                        state_next = WB;
                    end
                end
                WB: begin
                    pc_we  = 1'b1;
                    rf_we  = ~(is_store | is_branch);
                    if (is_load) begin
                        wb_sel = 2'd1;
                    end else if (is_jal | is_jalr) begin
                        wb_sel = 2'd2;
                    end
                    if (is_jal | (is_branch & taken_q)) begin
                        pc_src = 2'd1;
                    end else if (is_jalr) begin
                        pc_src = 2'd2;
                    end
                    state_next = FETCH;
                end
                TRAP: begin
                    halt = 1'b1;
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

`ifdef RV32I_CTRL_PERF_CNT_EN
    logic [31:0] cycle_q;
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (state == WB) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = 32'd0;
    assign instret_cnt = 32'd0;
`endif

endmodule
